// File: rtl/fpu_div_pkg.sv
// Shared types and constants for the divider front-end sequencer:
// FSM states, operand classes, canonical NaN and result flag positions.
package fpu_div_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLASSIFY,
      LAUNCH,
      WAIT,
      DONE
   } div_seq_state_t;

   typedef enum logic [2:0] {
      FP_ZERO,
      FP_SUB,
      FP_NORM,
      FP_INF,
      FP_NAN
   } fp_class_t;

   localparam logic [31:0] QNAN32 = 32'h7FC00000;

   localparam int FLG_INV = 0;
   localparam int FLG_DZ  = 1;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 3;
   localparam int FLG_TMO = 4;

   function automatic logic [31:0] fp_inf(input logic s);
      return {s, 8'hFF, 23'h0};
   endfunction

   function automatic logic [31:0] fp_zero(input logic s);
      return {s, 31'h0};
   endfunction

endpackage

// File: rtl/fpu_div_sequencer_if.sv
// Operand/result valid-ready bundle of the divider sequencer.
// slave: sequencer side; master: producer/consumer side.
interface fpu_div_sequencer_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_q;
   logic [4:0]  out_flags;

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_q, out_flags
   );

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_q, out_flags
   );

endinterface

// File: rtl/fp32_classify.sv
// Combinational binary32 classifier.
// Ports: x (operand) -> cls (zero/sub/norm/inf/nan), sign.
module fp32_classify
   import fpu_div_pkg::*;
(
   input  logic [31:0] x,
   output fp_class_t   cls,
   output logic        sign
);

   logic [7:0]  exp_w;
   logic [22:0] man_w;

   assign exp_w = x[30:23];
   assign man_w = x[22:0];
   assign sign  = x[31];

   always_comb begin
      cls = FP_NORM;
      unique case (1'b1)
         (exp_w == 8'h00) && (man_w == '0): cls = FP_ZERO;
         (exp_w == 8'h00) && (man_w != '0): cls = FP_SUB;
         (exp_w == 8'hFF) && (man_w == '0): cls = FP_INF;
         (exp_w == 8'hFF) && (man_w != '0): cls = FP_NAN;
         default:                           cls = FP_NORM;
      endcase
   end

endmodule

// File: rtl/fpu_div_sequencer.sv
// Flow-controlled front-end for the iterative FP32 divider: resolves special
// operands locally, launches ordinary ones, waits for fin with a timeout.
// Ports: clk, rst_n, io (in/out valid-ready bundle), div_a/div_b/div_start
// to the divider, div_q/div_fin from it.
module fpu_div_sequencer
   import fpu_div_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   fpu_div_sequencer_if.slave         io,
   output logic [31:0]                div_a,
   output logic [31:0]                div_b,
   output logic                       div_start,
   input  logic [31:0]                div_q,
   input  logic                       div_fin
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   div_seq_state_t state_q, state_d;
   logic [31:0]    a_q, a_d, b_q, b_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           in_ready_q, in_ready_d;
   logic           out_valid_q, out_valid_d;
   logic [31:0]    res_q, res_d;
   logic [4:0]     flg_q, flg_d;
   logic           start_q, start_d;
   logic [31:0]    da_q, da_d, db_q, db_d;

   fp_class_t cls_a, cls_b;
   logic      sgn_a, sgn_b;
   logic      s, za, zb, ia, ib, na, nb;

   fp32_classify u_cls_a (.x(a_q), .cls(cls_a), .sign(sgn_a));
   fp32_classify u_cls_b (.x(b_q), .cls(cls_b), .sign(sgn_b));

   // Subnormals count as zero (flush-to-zero).
   assign s  = sgn_a ^ sgn_b;
   assign za = (cls_a == FP_ZERO) || (cls_a == FP_SUB);
   assign zb = (cls_b == FP_ZERO) || (cls_b == FP_SUB);
   assign ia = (cls_a == FP_INF);
   assign ib = (cls_b == FP_INF);
   assign na = (cls_a == FP_NAN);
   assign nb = (cls_b == FP_NAN);

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      res_d       = res_q;
      flg_d       = flg_q;
      start_d     = 1'b0;
      da_d        = da_q;
      db_d        = db_q;
      unique case (state_q)
         IDLE: begin
            if (io.in_valid && in_ready_q) begin
               a_d        = io.in_a;
               b_d        = io.in_b;
               in_ready_d = 1'b0;
               state_d    = CLASSIFY;
            end
         end
         CLASSIFY: begin
            flg_d       = '0;
            state_d     = DONE;
            out_valid_d = 1'b1;
            if (na || nb || (za && zb) || (ia && ib)) begin
               res_d          = QNAN32;
               flg_d[FLG_INV] = 1'b1;
            end else if (ia) begin
               res_d = fp_inf(s);
            end else if (zb) begin
               res_d         = fp_inf(s);
               flg_d[FLG_DZ] = 1'b1;
            end else if (za || ib) begin
               res_d = fp_zero(s);
            end else begin
               state_d     = LAUNCH;
               out_valid_d = 1'b0;
               start_d     = 1'b1;
               da_d        = a_q;
               db_d        = b_q;
            end
         end
         LAUNCH: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + CW'(1);
            // fin takes priority over a coincident timeout.
            if (div_fin) begin
               res_d          = div_q;
               flg_d          = '0;
               flg_d[FLG_OVF] = &div_q[30:23];
               flg_d[FLG_UNF] = ~|div_q[30:0];
               out_valid_d    = 1'b1;
               state_d        = DONE;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               res_d          = QNAN32;
               flg_d          = '0;
               flg_d[FLG_TMO] = 1'b1;
               out_valid_d    = 1'b1;
               state_d        = DONE;
            end
         end
         DONE: begin
            if (io.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         flg_q       <= '0;
         start_q     <= 1'b0;
         da_q        <= '0;
         db_q        <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         flg_q       <= flg_d;
         start_q     <= start_d;
         da_q        <= da_d;
         db_q        <= db_d;
      end
   end

   assign io.in_ready  = in_ready_q;
   assign io.out_valid = out_valid_q;
   assign io.out_q     = res_q;
   assign io.out_flags = flg_q;
   assign div_start    = start_q;
   assign div_a        = da_q;
   assign div_b        = db_q;

endmodule

// File: doc/fpu_div_sequencer.md
# fpu_div_sequencer

Upstream front-end for the iterative single-precision divider `FPU_division`. It accepts operand pairs over a valid/ready handshake and resolves IEEE-754 special cases locally, without invoking the divider. Ordinary operands are launched into the divider; the block waits for its `fin`, then presents the quotient and status flags over an output valid/ready handshake. It converts the free-running divider into a flow-controlled, one-operation-in-flight unit.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent in WAIT before the operation is abandoned.
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset. The divider shares this reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept a pair.
- `in_a` in 32: dividend, IEEE-754 binary32.
- `in_b` in 32: divisor, IEEE-754 binary32.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_q` out 32: quotient.
- `out_flags` out 5: {timeout, underflow, overflow, divzero, invalid}, bits [4:0].
- `div_a`, `div_b` out 32: operands to the divider.
- `div_start` out 1: one-cycle launch pulse.
- `div_q` in 32: divider result.
- `div_fin` in 1: divider done, sampled only in WAIT.

## Operation
- FSM states: IDLE, CLASSIFY, LAUNCH, WAIT, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `in_a`/`in_b` and go to CLASSIFY.
- CLASSIFY: classify each latched operand as zero, subnormal, normal, inf or NaN. Subnormals are flushed to zero (FTZ). Sign is `a[31]^b[31]`. Special cases go to DONE with:
  - Either operand NaN, 0/0 or inf/inf: `32'h7FC00000` (canonical qNaN, sign 0), `invalid`.
  - Finite nonzero/0: signed inf (`{s,8'hFF,23'h0}`), `divzero`.
  - inf/finite: signed inf, no flag.
  - 0/nonzero-finite or finite/inf: signed zero, no flag.
  - Otherwise go to LAUNCH.
- LAUNCH
  - Drive `div_a`/`div_b` from the latches and assert `div_start` for exactly one cycle.
  - Clear the timeout counter and go to WAIT.
- WAIT: increment the counter each cycle.
  - On `div_fin`=1: capture `div_q` and go to DONE.
    - Set `overflow` if `div_q[30:23]==8'hFF`.
    - Set `underflow` if `div_q[30:0]==0`, since both operands are nonzero here.
  - On counter reaching `TIMEOUT_CYCLES-1` without `div_fin`: result qNaN, set `timeout`, go to DONE.
  - If `div_fin` and timeout occur in the same cycle, `div_fin` wins.
- DONE
  - `out_valid`=1; `out_q`/`out_flags` are held stable.
  - On `out_ready`, go to IDLE.
- `div_a`/`div_b` stay stable from LAUNCH until the block next leaves IDLE.
- `div_fin` outside WAIT is ignored.

## Timing
- Reset values:
  - State IDLE, so `in_ready`=1.
  - `out_valid`=0, `out_q`=0, `out_flags`=0.
  - `div_start`=0, `div_a`=`div_b`=0.
  - Counter 0.
- Special case: acceptance edge (cycle 0), CLASSIFY in cycle 1, `out_valid` high in cycle 2.
- Normal case:
  - `div_start` is high in cycle 2.
  - `out_valid` rises the cycle after the WAIT cycle in which `div_fin`=1, so latency = 3 + divider latency.
- Output handshake: the result transfers on the edge where `out_valid && out_ready`. `in_ready` rises on the following cycle, so throughput is one operation per (latency+1) cycles. No output skid buffering.
- `out_ready` held low keeps DONE indefinitely with outputs unchanged.
- Reset asserted mid-operation (any state) returns the block to IDLE at once and clears all outputs. The divider is reset with it, so no stale `div_fin` can follow.

## Structure
- Package `fpu_div_pkg`:
  - state enum `div_seq_state_t`.
  - class enum `fp_class_t` {FP_ZERO, FP_SUB, FP_NORM, FP_INF, FP_NAN}.
  - `QNAN32` = 32'h7FC00000.
  - Flag bit index localparams `FLG_INV`, `FLG_DZ`, `FLG_OVF`, `FLG_UNF`, `FLG_TMO`.
- Sub-module `fp32_classify`: combinational, 32-bit in, `fp_class_t` + sign out; instantiated twice.

## Test plan
- `in_a`=0x40C00000 (6.0), `in_b`=0x40000000 (2.0), divider model returns 0x40400000 after 52 cycles -> one `div_start` pulse, `out_q`=0x40400000, `out_flags`=0, `out_valid` at cycle 55.
- 0x3F800000 / 0x00000000 -> no `div_start`, `out_q`=0x7F800000, flags=5'b00010, `out_valid` at cycle 2.
- 0/0 and 0x7F800000/0x7F800000 -> `out_q`=0x7FC00000, flags=5'b00001. 0xBF800000 / 0x7F800000 -> `out_q`=0x80000000, flags=0.
- Normal operands with `div_fin` never asserted, `TIMEOUT_CYCLES`=64 -> `out_q`=0x7FC00000, flags=5'b10000. Repeat with `div_fin` on the final count cycle -> divider result used, `timeout`=0.
- `out_ready` low for 20 cycles in DONE -> `out_q` stable, `in_ready`=0, `in_valid` ignored. Raise `out_ready` -> `in_ready`=1 next cycle.
- `rst_n` pulsed low mid-WAIT -> immediate IDLE, all outputs zero. A fresh 6.0/2.0 then completes correctly.
